// File: rtl/mips_mem_responder.sv
// mips_mem_responder
// Memory-side responder for the multicycle MIPS core bus. Holds the unified
// instruction/data array, answers core reads combinationally, commits core
// writes on the clock edge, and contains a byte-serial program loader that
// holds the core (CPU_HOLD) while it fills memory from word 0.
//
// Handshake: a load byte is transferred on a rising CLK edge where
// LD_VALID && LD_READY are both high; LD_BYTE and LD_LAST are only
// meaningful while LD_VALID is high.
//
// Optional feature: define MIPS_MEM_STATS_EN to build the core read/write
// cycle counters on STAT_RD / STAT_WR; otherwise both outputs are tied to 0.
//
// Debug: fsm_state exposes the loader FSM (0 IDLE, 1 LOAD, 2 DRAIN) and
// bus_drive shows when this block is driving Mem_Bus.
module mips_mem_responder #(
   parameter int ADDR_W    = 7,
   parameter int POST_HOLD = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CS,
   input  logic              WE,
   input  logic [ADDR_W-1:0] ADDR,
   inout  wire  [31:0]       Mem_Bus,
   input  logic              LD_START,
   input  logic              LD_VALID,
   input  logic [7:0]        LD_BYTE,
   input  logic              LD_LAST,
   output logic              LD_READY,
   output logic              CPU_HOLD,
   output logic [ADDR_W:0]   LD_WORDS,
   output logic [15:0]       STAT_RD,
   output logic [15:0]       STAT_WR,
   output logic [1:0]        fsm_state,
   output logic              bus_drive
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      HOLD_INIT = 4'(POST_HOLD - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   waddr;
   logic [1:0]          byte_cnt;
   logic [23:0]         asm_reg;
   logic [3:0]          hold_cnt;
   logic [31:0]         mem [DEPTH];

   logic                core_en;
   logic                core_rd;
   logic                core_wr;
   logic                ld_fire;
   logic                ld_commit;
   logic [31:0]         ld_word;
   logic [31:0]         rd_data;

   // The core port is live only in IDLE and outside reset; the loader owns memory otherwise.
   assign core_en   = (state == S_IDLE) && !RST && CS;
   assign core_rd   = core_en && !WE;
   assign core_wr   = core_en && WE;
   assign ld_fire   = (state == S_LOAD) && !RST && LD_VALID;
   assign ld_commit = ld_fire && ((byte_cnt == 2'd3) || LD_LAST);

   // Zero-latency read: the core latches Mem_Bus at the edge that ends its CS cycle.
   assign rd_data   = mem[ADDR];
   assign Mem_Bus   = core_rd ? rd_data : 32'bz;
   assign bus_drive = core_rd;
   assign fsm_state = state;

   // Assemble the word being committed: earlier bytes high, short words zero-padded low.
   always_comb begin
      ld_word = 32'h0;
      case (byte_cnt)
         2'd0:    ld_word = {LD_BYTE, 24'h0};
         2'd1:    ld_word = {asm_reg[7:0], LD_BYTE, 16'h0};
         2'd2:    ld_word = {asm_reg[15:0], LD_BYTE, 8'h0};
         default: ld_word = {asm_reg[23:0], LD_BYTE};
      endcase
   end

   // Single write port shared by core writes (IDLE) and loader commits (LOAD); never reset.
   always_ff @(posedge CLK) begin
      if (core_wr)
         mem[ADDR] <= Mem_Bus;
      else if (ld_commit)
         mem[waddr] <= ld_word;
   end

   // Loader FSM with registered LD_READY / CPU_HOLD.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= S_IDLE;
         waddr    <= '0;
         byte_cnt <= 2'd0;
         asm_reg  <= 24'h0;
         LD_WORDS <= '0;
         hold_cnt <= 4'd0;
         LD_READY <= 1'b0;
         CPU_HOLD <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (LD_START) begin
                  state    <= S_LOAD;
                  waddr    <= '0;
                  byte_cnt <= 2'd0;
                  LD_WORDS <= '0;
                  LD_READY <= 1'b1;
                  CPU_HOLD <= 1'b1;
               end
            end
            S_LOAD: begin
               if (ld_fire) begin
                  asm_reg <= {asm_reg[15:0], LD_BYTE};
                  if (ld_commit) begin
                     waddr    <= waddr + ADDR_W'(1);
                     byte_cnt <= 2'd0;
                     if (LD_WORDS != WORDS_MAX)
                        LD_WORDS <= LD_WORDS + (ADDR_W+1)'(1);
                  end else begin
                     byte_cnt <= byte_cnt + 2'd1;
                  end
                  if (LD_LAST) begin
                     state    <= S_DRAIN;
                     LD_READY <= 1'b0;
                     hold_cnt <= HOLD_INIT;
                  end
               end
            end
            S_DRAIN: begin
               if (hold_cnt == 4'd0) begin
                  state    <= S_IDLE;
                  CPU_HOLD <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt - 4'd1;
               end
            end
            default: begin
               state    <= S_IDLE;
               LD_READY <= 1'b0;
               CPU_HOLD <= 1'b0;
            end
         endcase
      end
   end

`ifdef MIPS_MEM_STATS_EN
   // Saturating core access counters, cleared by reset and by the start of a load.
   always_ff @(posedge CLK) begin
      if (RST || ((state == S_IDLE) && LD_START)) begin
         STAT_RD <= 16'h0;
         STAT_WR <= 16'h0;
      end else begin
         if (core_rd && (STAT_RD != 16'hFFFF))
            STAT_RD <= STAT_RD + 16'd1;
         if (core_wr && (STAT_WR != 16'hFFFF))
            STAT_WR <= STAT_WR + 16'd1;
      end
   end
`else
   assign STAT_RD = 16'h0;
   assign STAT_WR = 16'h0;
`endif

endmodule

// File: tb/tb_mips_mem_responder.sv
// tb_mips_mem_responder
// Bench for mips_mem_responder: core read/write, program loader, wrap and
// saturation, reset during load, and the optional access counters
// (MIPS_MEM_STATS_EN).
module tb_mips_mem_responder;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        CS = 1'b0;
   logic        WE = 1'b0;
   logic [6:0]  ADDR = 7'd0;
   wire  [31:0] Mem_Bus;
   logic        LD_START = 1'b0;
   logic        LD_VALID = 1'b0;
   logic [7:0]  LD_BYTE = 8'h0;
   logic        LD_LAST = 1'b0;
   logic        LD_READY;
   logic        CPU_HOLD;
   logic [7:0]  LD_WORDS;
   logic [15:0] STAT_RD;
   logic [15:0] STAT_WR;
   logic [1:0]  fsm_state;
   logic        bus_drive;

   logic        bus_en = 1'b0;
   logic [31:0] bus_out = 32'h0;
   assign Mem_Bus = bus_en ? bus_out : 32'bz;

   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] model_mem [128];
   logic [31:0] exp_q [$];

   // Clock/reset block
   always #5 CLK = ~CLK;

   mips_mem_responder #(.ADDR_W(7), .POST_HOLD(2)) dut (
      .CLK(CLK), .RST(RST), .CS(CS), .WE(WE), .ADDR(ADDR), .Mem_Bus(Mem_Bus),
      .LD_START(LD_START), .LD_VALID(LD_VALID), .LD_BYTE(LD_BYTE), .LD_LAST(LD_LAST),
      .LD_READY(LD_READY), .CPU_HOLD(CPU_HOLD), .LD_WORDS(LD_WORDS),
      .STAT_RD(STAT_RD), .STAT_WR(STAT_WR), .fsm_state(fsm_state), .bus_drive(bus_drive)
   );

   function automatic logic [31:0] pat(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, 8'h3C, b ^ 8'h96};
   endfunction

   // Driver: one core bus access holding CS for 'cycles' edges; samples the bus mid-cycle.
   task automatic core_cycle(input logic cs, input logic we, input logic [6:0] addr,
                             input logic [31:0] wdata, input int cycles,
                             output logic [31:0] seen, output logic oe_seen);
      @(posedge CLK); #1;
      CS = cs; WE = we; ADDR = addr; bus_out = wdata; bus_en = cs && we;
      @(negedge CLK);
      seen = Mem_Bus;
      oe_seen = bus_drive;
      repeat (cycles) @(posedge CLK);
      #1;
      CS = 1'b0; WE = 1'b0; bus_en = 1'b0;
   endtask

   // Driver: pulse LD_START; returns just after the edge that enters LOAD.
   task automatic start_load();
      @(posedge CLK); #1 LD_START = 1'b1;
      @(posedge CLK); #1 LD_START = 1'b0;
   endtask

   // Driver: present one byte (called just after a posedge), return after it is accepted.
   task automatic load_byte(input logic [7:0] b, input logic last);
      int waited;
      waited = 0;
      LD_VALID = 1'b1; LD_BYTE = b; LD_LAST = last;
      @(negedge CLK);
      while (!LD_READY && waited < 20) begin
         @(negedge CLK);
         waited++;
      end
      if (!LD_READY) begin
         n_total++;
         $display("FAIL load_ready_timeout: LD_READY=%0b required 1 within 20 cycles", LD_READY);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 CS = 1'b1; WE = 1'b0; ADDR = 7'd0;
      @(negedge CLK);
      n_total++; if (LD_READY !== 1'b0) $display("FAIL rst_ld_ready: got %0b want 0", LD_READY); else n_pass++;
      n_total++; if (CPU_HOLD !== 1'b0) $display("FAIL rst_cpu_hold: got %0b want 0", CPU_HOLD); else n_pass++;
      n_total++; if (LD_WORDS !== 8'd0) $display("FAIL rst_ld_words: got %0d want 0", LD_WORDS); else n_pass++;
      n_total++; if (fsm_state !== 2'd0) $display("FAIL rst_state: got %0d want 0", fsm_state); else n_pass++;
      n_total++; if (bus_drive !== 1'b0) $display("FAIL rst_bus_z: drive=%0b want 0", bus_drive); else n_pass++;
      n_total++; if (STAT_RD !== 16'd0 || STAT_WR !== 16'd0)
         $display("FAIL rst_stats: got %0d/%0d want 0/0", STAT_RD, STAT_WR); else n_pass++;
      @(posedge CLK); #1;
      RST = 1'b0; CS = 1'b0;
   endtask

   task automatic test_core_rw();
      logic [31:0] seen, got;
      logic        oe;
      logic [6:0]  a [4];
      core_cycle(1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 1, seen, oe);
      model_mem[5] = 32'hDEADBEEF;
      n_total++; if (oe !== 1'b0) $display("FAIL write_no_drive: drive=%0b want 0", oe); else n_pass++;
      exp_q.push_back(model_mem[5]);
      core_cycle(1'b1, 1'b0, 7'd5, 32'h0, 1, seen, oe);
      got = exp_q.pop_front();
      n_total++; if (seen !== got) $display("FAIL read_addr5: got %h want %h", seen, got); else n_pass++;
      n_total++; if (oe !== 1'b1) $display("FAIL read_drive: drive=%0b want 1", oe); else n_pass++;
      core_cycle(1'b0, 1'b0, 7'd5, 32'h0, 1, seen, oe);
      n_total++; if (oe !== 1'b0) $display("FAIL idle_bus_z: drive=%0b want 0", oe); else n_pass++;
      // Random write/read-back on distinct addresses away from the loader's low words.
      for (int i = 0; i < 4; i++) begin
         a[i] = 7'(16 + i * 20 + $urandom_range(0, 15));
         model_mem[a[i]] = $urandom;
         core_cycle(1'b1, 1'b1, a[i], model_mem[a[i]], 1, seen, oe);
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(model_mem[a[i]]);
         core_cycle(1'b1, 1'b0, a[i], 32'h0, 1, seen, oe);
         got = exp_q.pop_front();
         n_total++; if (seen !== got) $display("FAIL read_rand%0d: addr %0d got %h want %h", i, a[i], seen, got); else n_pass++;
      end
   endtask

   task automatic test_stats();
      logic [31:0] seen;
      logic        oe;
      logic [15:0] exp_rd, exp_wr;
`ifdef MIPS_MEM_STATS_EN
      exp_rd = 16'd5; exp_wr = 16'd1;
`else
      exp_rd = 16'd0; exp_wr = 16'd0;
`endif
      @(posedge CLK); #1 RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      for (int i = 0; i < 3; i++) core_cycle(1'b1, 1'b0, 7'd5, 32'h0, 1, seen, oe);
      core_cycle(1'b1, 1'b0, 7'd5, 32'h0, 2, seen, oe);
      core_cycle(1'b1, 1'b1, 7'd9, 32'h0BADF00D, 1, seen, oe);
      model_mem[9] = 32'h0BADF00D;
      @(negedge CLK);
      n_total++; if (STAT_RD !== exp_rd) $display("FAIL stat_rd: got %0d want %0d", STAT_RD, exp_rd); else n_pass++;
      n_total++; if (STAT_WR !== exp_wr) $display("FAIL stat_wr: got %0d want %0d", STAT_WR, exp_wr); else n_pass++;
      // Memory contents survive the reset at the start of this test.
      exp_q.push_back(model_mem[5]);
      core_cycle(1'b1, 1'b0, 7'd5, 32'h0, 1, seen, oe);
      begin
         logic [31:0] got;
         got = exp_q.pop_front();
         n_total++; if (seen !== got) $display("FAIL mem_survives_rst: got %h want %h", seen, got); else n_pass++;
      end
   endtask

   task automatic test_load();
      logic [31:0] seen, got;
      logic        oe;
      logic [7:0]  bytes [4];
      bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
      start_load();
      @(negedge CLK);
      n_total++; if (CPU_HOLD !== 1'b1 || LD_READY !== 1'b1)
         $display("FAIL load_entry: hold=%0b ready=%0b want 1/1", CPU_HOLD, LD_READY); else n_pass++;
      @(posedge CLK); #1;
      for (int k = 0; k < 4; k++) load_byte(bytes[k], 1'b0);
      LD_VALID = 1'b0;
      // Core access during LOAD must be ignored.
      core_cycle(1'b1, 1'b1, 7'd0, 32'hFFFFFFFF, 1, seen, oe);
      core_cycle(1'b1, 1'b0, 7'd0, 32'h0, 1, seen, oe);
      n_total++; if (oe !== 1'b0) $display("FAIL load_core_read_z: drive=%0b want 0", oe); else n_pass++;
      load_byte(8'h9A, 1'b1);
      LD_VALID = 1'b0; LD_LAST = 1'b0;
      model_mem[0] = 32'h12345678;
      model_mem[1] = 32'h9A000000;
      @(negedge CLK);
      n_total++; if (CPU_HOLD !== 1'b1 || LD_READY !== 1'b0 || fsm_state !== 2'd2)
         $display("FAIL drain_1: hold=%0b ready=%0b state=%0d want 1/0/2", CPU_HOLD, LD_READY, fsm_state); else n_pass++;
      n_total++; if (LD_WORDS !== 8'd2) $display("FAIL ld_words_2: got %0d want 2", LD_WORDS); else n_pass++;
      @(negedge CLK);
      n_total++; if (CPU_HOLD !== 1'b1) $display("FAIL drain_2: hold=%0b want 1", CPU_HOLD); else n_pass++;
      @(negedge CLK);
      n_total++; if (CPU_HOLD !== 1'b0 || fsm_state !== 2'd0)
         $display("FAIL drain_end: hold=%0b state=%0d want 0/0", CPU_HOLD, fsm_state); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(model_mem[i]);
         core_cycle(1'b1, 1'b0, 7'(i), 32'h0, 1, seen, oe);
         got = exp_q.pop_front();
         n_total++; if (seen !== got) $display("FAIL load_mem%0d: got %h want %h", i, seen, got); else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [31:0] seen, got, w;
      logic        oe;
      int          chk [3];
      chk[0] = 0; chk[1] = 1; chk[2] = 127;
      start_load();
      for (int i = 0; i < 129; i++) begin
         w = pat(i);
         for (int k = 0; k < 4; k++) load_byte(w[31 - 8*k -: 8], (i == 128) && (k == 3));
         model_mem[i % 128] = w;
      end
      LD_VALID = 1'b0; LD_LAST = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      n_total++; if (LD_WORDS !== 8'd128) $display("FAIL ld_words_sat: got %0d want 128", LD_WORDS); else n_pass++;
      n_total++; if (fsm_state !== 2'd0 || CPU_HOLD !== 1'b0)
         $display("FAIL wrap_idle: state=%0d hold=%0b want 0/0", fsm_state, CPU_HOLD); else n_pass++;
      for (int j = 0; j < 3; j++) begin
         exp_q.push_back(model_mem[chk[j]]);
         core_cycle(1'b1, 1'b0, 7'(chk[j]), 32'h0, 1, seen, oe);
         got = exp_q.pop_front();
         n_total++; if (seen !== got) $display("FAIL wrap_mem%0d: got %h want %h", chk[j], seen, got); else n_pass++;
      end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] seen, got;
      logic        oe;
      core_cycle(1'b1, 1'b1, 7'd1, 32'hCAFEF00D, 1, seen, oe);
      model_mem[1] = 32'hCAFEF00D;
      start_load();
      for (int k = 0; k < 6; k++) load_byte(8'(8'h11 + k), 1'b0);
      LD_VALID = 1'b0;
      model_mem[0] = 32'h11121314;
      RST = 1'b1;
      @(posedge CLK); #1 RST = 1'b0;
      @(negedge CLK);
      n_total++; if (CPU_HOLD !== 1'b0 || LD_READY !== 1'b0 || fsm_state !== 2'd0)
         $display("FAIL rst_mid_load: hold=%0b ready=%0b state=%0d want 0/0/0", CPU_HOLD, LD_READY, fsm_state); else n_pass++;
      n_total++; if (LD_WORDS !== 8'd0) $display("FAIL rst_mid_words: got %0d want 0", LD_WORDS); else n_pass++;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(model_mem[i]);
         core_cycle(1'b1, 1'b0, 7'(i), 32'h0, 1, seen, oe);
         got = exp_q.pop_front();
         n_total++; if (seen !== got) $display("FAIL rst_mid_mem%0d: got %h want %h", i, seen, got); else n_pass++;
      end
   endtask

   // Sequence and final report
   initial begin
      test_reset();
      test_core_rw();
      test_stats();
      test_load();
      test_wrap();
      test_reset_mid_load();
      repeat (2) @(posedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
